keypad_digits: RTL and testbench

Scans a 4x4 active-low matrix keypad and debounces each press. Every accepted key press produces exactly one hexadecimal digit. The block keeps the last two accepted digits as `s0` (newest) and `s1` (previous). It sits directly upstream of the dual 7-segment multiplexer and LED adder, replacing the DIP-switch digit inputs. It runs on the 24 MHz HSOSC clock.

---
 rtl/keypad_digits_if.sv | 13 +
 rtl/keypad_digits.sv | 160 ++++++++++++++++
 tb/tb_keypad_digits.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_digits_if.sv
// Keypad-side and digit-side signals of keypad_digits.
// The slave view belongs to the scanner, which drives the rows and digits.
// The master view belongs to whatever models or hosts the keypad.
interface keypad_digits_if;
    logic [3:0] col;        // active-low columns, pulled up off-chip
    logic [3:0] row;        // active-low row drive, at most one bit low
    logic [3:0] s0;         // newest accepted digit
    logic [3:0] s1;         // previous accepted digit
    logic       key_valid;  // one-cycle pulse when s0/s1 update

    modport slave  (input  col, output row, s0, s1, key_valid);
    modport master (output col, input  row, s0, s1, key_valid);
endinterface

// File: rtl/keypad_digits.sv
// 4x4 active-low matrix keypad scanner with press and release debounce.
// Each accepted press shifts a hex digit into s0, and the old s0 moves to s1.
// key_valid pulses for one cycle on that update.
module keypad_digits #(
    parameter int SCAN_CYCLES     = 24000,
    parameter int DEBOUNCE_CYCLES = 480000
) (
    input  logic             int_osc,
    input  logic             reset,
    keypad_digits_if.slave   kp
);
    localparam int MAXC = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HOLD, DEB_REL} state_t;

    state_t          state_q, state_d;
    logic [1:0]      ridx_q, ridx_d;
    logic [1:0]      cidx_q, cidx_d;
    logic [3:0]      pat_q, pat_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      row_q, row_d;
    logic [3:0]      s0_q, s0_d;
    logic [3:0]      s1_q, s1_d;
    logic            kv_q, kv_d;
    logic [3:0]      sync1_q, sync1_d;
    logic [3:0]      cols_q, cols_d;

    logic [3:0]      col_low;
    logic            one_low;
    logic [1:0]      cidx_new;

    // Map the (row, column) position to the printed legend of the key.
    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Decode the synchronized columns: exactly one low column, and which one.
    always_comb begin
        col_low  = ~cols_q;
        one_low  = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);
        cidx_new = 2'd0;
        case (cols_q)
            4'b1101: cidx_new = 2'd1;
            4'b1011: cidx_new = 2'd2;
            4'b0111: cidx_new = 2'd3;
            default: cidx_new = 2'd0;
        endcase
    end

    // Scanner FSM next-state logic, counters, digit shift and column synchronizer.
    always_comb begin
        state_d = state_q;
        ridx_d  = ridx_q;
        cidx_d  = cidx_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        kv_d    = 1'b0;
        sync1_d = kp.col;
        cols_d  = sync1_q;

        case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (one_low) begin
                        pat_d   = cols_q;
                        cidx_d  = cidx_new;
                        state_d = DEB_PRESS;
                    end else begin
                        ridx_d = ridx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DEB_PRESS: begin
                if (cols_q != pat_q) begin
                    // Any change restarts scanning on the same row.
                    cnt_d   = '0;
                    state_d = SCAN;
                end else if (cnt_q == DEB_LAST) begin
                    s1_d    = s0_q;
                    s0_d    = keymap(ridx_q, cidx_q);
                    kv_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                // Only the latched column matters; other keys are ignored.
                if (cols_q[cidx_q]) begin
                    cnt_d   = '0;
                    state_d = DEB_REL;
                end
            end
            default: begin  // DEB_REL
                if (!cols_q[cidx_q]) begin
                    state_d = HOLD;
                end else if (cnt_q == DEB_LAST) begin
                    ridx_d  = ridx_q + 2'd1;
                    cnt_d   = '0;
                    state_d = SCAN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase

        // The row register follows ridx, so it moves exactly when ridx advances.
        row_d = ~(4'b0001 << ridx_d);
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge int_osc) begin
        if (!reset) begin
            state_q <= SCAN;
            ridx_q  <= 2'd0;
            cidx_q  <= 2'd0;
            pat_q   <= 4'b1111;
            cnt_q   <= '0;
            row_q   <= 4'b1110;
            s0_q    <= 4'h0;
            s1_q    <= 4'h0;
            kv_q    <= 1'b0;
            sync1_q <= 4'b1111;
            cols_q  <= 4'b1111;
        end else begin
            state_q <= state_d;
            ridx_q  <= ridx_d;
            cidx_q  <= cidx_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            kv_q    <= kv_d;
            sync1_q <= sync1_d;
            cols_q  <= cols_d;
        end
    end

    assign kp.row       = row_q;
    assign kp.s0        = s0_q;
    assign kp.s1        = s1_q;
    assign kp.key_valid = kv_q;
endmodule

// File: tb/tb_keypad_digits.sv
// Directed bench for keypad_digits with a behavioural 4x4 keypad model.
// A pressed key pulls its column low whenever its row is driven low.
module tb_keypad_digits;
    logic        int_osc = 1'b0;
    logic        reset   = 1'b0;
    logic [15:0] pressed = 16'h0;   // bit r*4+c
    logic [3:0]  col_drv;

    int checks = 0;
    int errors = 0;
    int kv_cnt = 0;
    int kv_dbl = 0;
    bit kv_prev = 1'b0;

    keypad_digits_if kp ();

    keypad_digits #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
        .int_osc (int_osc),
        .reset   (reset),
        .kp      (kp.slave)
    );

    always #5 int_osc = ~int_osc;

    // Keypad model.
    always_comb begin
        col_drv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp.row[r]) col_drv[c] = 1'b0;
    end
    assign kp.col = col_drv;

    // Count key_valid pulses and flag back-to-back highs.
    always @(negedge int_osc) begin
        if (kp.key_valid === 1'b1) begin
            kv_cnt++;
            if (kv_prev) kv_dbl++;
        end
        kv_prev = (kp.key_valid === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge int_osc);
    endtask

    task automatic wait_kv(input int max, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < max && !got; i++) begin
            @(negedge int_osc);
            if (kp.key_valid === 1'b1) got = 1'b1;
        end
        chk({tag, "_kv_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        int base;
        bit seen_r3;

        // Reset state and row rotation.
        reset = 1'b0;
        tick(3);
        chk("rst_row", 32'(kp.row), 32'hE);
        chk("rst_s0", 32'(kp.s0), 32'h0);
        chk("rst_s1", 32'(kp.s1), 32'h0);
        chk("rst_kv", 32'(kp.key_valid), 32'h0);
        reset = 1'b1;
        tick(3);
        chk("rot_hold", 32'(kp.row), 32'hE);
        tick(1);
        chk("rot_1", 32'(kp.row), 32'hD);
        tick(4);
        chk("rot_2", 32'(kp.row), 32'hB);
        tick(4);
        chk("rot_3", 32'(kp.row), 32'h7);
        tick(4);
        chk("rot_0", 32'(kp.row), 32'hE);

        // Clean press '5' then 'A'.
        base = kv_cnt;
        pressed = 16'h0020;
        wait_kv(200, "k5");
        chk("k5_s0", 32'(kp.s0), 32'h5);
        chk("k5_s1", 32'(kp.s1), 32'h0);
        tick(20);
        pressed = 16'h0;
        tick(30);
        chk("k5_pulses", 32'(kv_cnt - base), 32'd1);

        base = kv_cnt;
        pressed = 16'h0008;
        wait_kv(200, "kA");
        chk("kA_s0", 32'(kp.s0), 32'hA);
        chk("kA_s1", 32'(kp.s1), 32'h5);
        tick(10);
        pressed = 16'h0;
        tick(30);
        chk("kA_pulses", 32'(kv_cnt - base), 32'd1);

        // Press bounce on '9'.
        base = kv_cnt;
        for (int i = 0; i < 7; i++) begin
            pressed = (i % 2 == 0) ? 16'h0400 : 16'h0;
            tick(3);
        end
        chk("k9_bounce", 32'(kv_cnt - base), 32'd0);
        pressed = 16'h0400;
        wait_kv(200, "k9");
        chk("k9_s0", 32'(kp.s0), 32'h9);
        chk("k9_s1", 32'(kp.s1), 32'hA);
        pressed = 16'h0;
        tick(30);
        chk("k9_pulses", 32'(kv_cnt - base), 32'd1);

        // Long hold of 'F' with bouncy release.
        base = kv_cnt;
        pressed = 16'h4000;
        wait_kv(200, "kF");
        chk("kF_s0", 32'(kp.s0), 32'hF);
        chk("kF_s1", 32'(kp.s1), 32'h9);
        tick(200);
        for (int i = 0; i < 6; i++) begin
            pressed = (i % 2 == 0) ? 16'h0 : 16'h4000;
            tick(3);
        end
        pressed = 16'h0;
        tick(40);
        chk("kF_pulses", 32'(kv_cnt - base), 32'd1);
        chk("kF_s0_hold", 32'(kp.s0), 32'hF);

        // Two keys in one row: never accepted, scanning goes on.
        base = kv_cnt;
        seen_r3 = 1'b0;
        pressed = 16'h0003;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (kp.row == 4'b0111) seen_r3 = 1'b1;
        end
        pressed = 16'h0;
        chk("k12_pulses", 32'(kv_cnt - base), 32'd0);
        chk("k12_scan", 32'(seen_r3), 32'd1);
        chk("k12_s0", 32'(kp.s0), 32'hF);
        chk("k12_s1", 32'(kp.s1), 32'h9);

        // Reset 4 cycles into DEB_PRESS for '7'.
        reset = 1'b0;
        tick(2);
        base = kv_cnt;
        reset = 1'b1;
        pressed = 16'h0100;
        tick(16);
        chk("k7_in_deb", 32'(kp.row), 32'hB);
        reset = 1'b0;
        pressed = 16'h0;
        tick(1);
        chk("k7_rst_row", 32'(kp.row), 32'hE);
        chk("k7_rst_s0", 32'(kp.s0), 32'h0);
        chk("k7_rst_kv", 32'(kp.key_valid), 32'h0);
        tick(1);
        reset = 1'b1;
        tick(30);
        chk("k7_pulses", 32'(kv_cnt - base), 32'd0);
        chk("k7_s0", 32'(kp.s0), 32'h0);
        chk("k7_s1", 32'(kp.s1), 32'h0);

        // Press-to-commit latency: row 2 sampled 12 cycles after release, commit 8 later.
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        pressed = 16'h0100;
        tick(19);
        chk("lat_early", 32'(kp.key_valid), 32'h0);
        tick(1);
        chk("lat_kv", 32'(kp.key_valid), 32'h1);
        chk("lat_s0", 32'(kp.s0), 32'h7);
        chk("lat_s1", 32'(kp.s1), 32'h0);
        pressed = 16'h0;
        tick(30);

        chk("kv_never_double", 32'(kv_dbl), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
